// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA geometry constants and plot-arbiter state encoding.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b10,
        RELEASE = 2'b11
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Round-robin selector; first set request after 'last', wrapping.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // One spare bit so last + offset never overflows before the wrap.
    logic [IDX_W:0] w_sum;

    // Scan offsets high to low so the nearest requester after 'last' wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_sum = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_sum = {1'b0, last} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NREQ);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
// ============================================================================
//  Module      : vga_plot_arbiter
//  Description : Round-robin owner of the VGA plot port for start/done engines.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_plot_arbiter
    import vga_pkg::arb_state_t, vga_pkg::IDLE, vga_pkg::RUN, vga_pkg::RELEASE;
#(
    parameter int NREQ = 2,
    parameter int X_W  = vga_pkg::X_W,
    parameter int Y_W  = vga_pkg::Y_W,
    parameter int C_W  = vga_pkg::C_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [NREQ-1:0]     eng_start,
    input  logic [NREQ-1:0]     eng_done,
    input  logic [NREQ*X_W-1:0] eng_x,
    input  logic [NREQ*Y_W-1:0] eng_y,
    input  logic [NREQ*C_W-1:0] eng_colour,
    input  logic [NREQ-1:0]     eng_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [C_W-1:0]      vga_colour,
    output logic                vga_plot
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_t       r_state, w_state_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic [NREQ-1:0]  r_ack,   w_ack_nxt;
    logic [IDX_W-1:0] r_last,  w_last_nxt;
    logic [IDX_W-1:0] r_sel,   w_sel_nxt;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_run;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_last  <= IDX_W'(NREQ - 1);
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Only the owner's done is ever looked at, so stray dones cannot end a job.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = RUN;
                    w_grant_nxt = NREQ'(1) << w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                end
            end
            RUN: begin
                if (eng_done[r_sel]) begin
                    w_state_nxt = RELEASE;
                    w_ack_nxt   = r_grant;
                end
            end
            RELEASE: begin
                if (!eng_done[r_sel]) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_sel_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
            end
        endcase
    end

    assign w_run     = (r_state == RUN);
    assign grant     = r_grant;
    assign ack       = r_ack;
    assign busy      = (r_state != IDLE);
    assign eng_start = w_run ? r_grant : '0;

    // Owner's pixel stream passes straight through; everything is zero otherwise.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (w_run) begin
            vga_x      = eng_x[r_sel*X_W +: X_W];
            vga_y      = eng_y[r_sel*Y_W +: Y_W];
            vga_colour = eng_colour[r_sel*C_W +: C_W];
            vga_plot   = eng_plot[r_sel];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
// ============================================================================
//  Module      : tb_vga_plot_arbiter
//  Description : Scoreboard bench for vga_plot_arbiter with two engine models.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_plot_arbiter;

    localparam int NREQ = 2;
    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     ack, grant, eng_start;
    logic                busy;
    logic [NREQ-1:0]     eng_done, eng_plot;
    logic [NREQ*X_W-1:0] eng_x;
    logic [NREQ*Y_W-1:0] eng_y;
    logic [NREQ*C_W-1:0] eng_colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [C_W-1:0]      vga_colour;
    logic                vga_plot;

    logic [X_W-1:0] ex [NREQ] = '{default: '0};
    logic [Y_W-1:0] ey [NREQ] = '{default: '0};
    logic [C_W-1:0] ec [NREQ] = '{default: '0};
    logic           eplot [NREQ] = '{default: 1'b0};
    logic           edone [NREQ] = '{default: 1'b0};
    bit             manual [NREQ] = '{default: 1'b0};
    bit             fill [NREQ] = '{default: 1'b0};
    int             job_n [NREQ] = '{default: 0};
    int             bx [NREQ] = '{default: 0};
    int             by [NREQ] = '{default: 0};
    int             bc [NREQ] = '{default: 0};

    logic [NREQ-1:0] q_grant [$];
    logic [NREQ-1:0] q_ack [$];
    logic [31:0]     q_plot [$];

    int n_chk = 0;
    int n_fail = 0;
    int plot_cnt = 0;
    logic [X_W-1:0] last_x = '0;
    logic [Y_W-1:0] last_y = '0;

    assign eng_x      = {ex[1], ex[0]};
    assign eng_y      = {ey[1], ey[0]};
    assign eng_colour = {ec[1], ec[0]};
    assign eng_plot   = {eplot[1], eplot[0]};
    assign eng_done   = {edone[1], edone[0]};

    vga_plot_arbiter #(
        .NREQ (NREQ), .X_W (X_W), .Y_W (Y_W), .C_W (C_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .grant      (grant),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y, input int c);
        return {14'd0, X_W'(x), Y_W'(y), C_W'(c)};
    endfunction

    // Engine model: one plot per cycle while started, then done until start drops.
    task automatic engine(input int e);
        int phase = 0;
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (manual[e]) begin
                phase = 0;
            end else if (rst) begin
                phase = 0;
                eplot[e] = 1'b0;
                edone[e] = 1'b0;
            end else begin
                if (phase == 0 && eng_start[e]) begin
                    phase = 1;
                    cnt = 0;
                end
                if (phase == 1) begin
                    if (!eng_start[e]) begin
                        phase = 0;
                        eplot[e] = 1'b0;
                    end else if (cnt < job_n[e]) begin
                        eplot[e] = 1'b1;
                        if (fill[e]) begin
                            ex[e] = X_W'(cnt % 160);
                            ey[e] = Y_W'(cnt / 160);
                        end else begin
                            ex[e] = X_W'(bx[e] + cnt);
                            ey[e] = Y_W'(by[e]);
                        end
                        ec[e] = C_W'(bc[e]);
                        cnt++;
                    end else begin
                        eplot[e] = 1'b0;
                        edone[e] = 1'b1;
                        phase = 2;
                    end
                end else if (phase == 2 && !eng_start[e]) begin
                    edone[e] = 1'b0;
                    phase = 0;
                end
            end
        end
    endtask

    initial engine(0);
    initial engine(1);

    task automatic push_job(input int e, input int n, input int x, input int y, input int c);
        fill[e]  = 1'b0;
        job_n[e] = n;
        bx[e] = x;
        by[e] = y;
        bc[e] = c;
        q_grant.push_back(NREQ'(1 << e));
        for (int i = 0; i < n; i++) q_plot.push_back(pk(x + i, y, c));
        q_ack.push_back(NREQ'(1 << e));
    endtask

    task automatic wait_ack(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            if (ack != '0) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            if (!busy) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: invariants every cycle, scoreboard pops on grant/ack/plot events.
    initial begin
        logic [NREQ-1:0] prev_grant = '0;
        forever begin
            @(negedge clk);
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            chk("start_in_grant", 32'(eng_start & ~grant), 32'd0);
            if (eng_start == '0)
                chk("idle_vga_zero", {14'd0, vga_x, vga_y, vga_colour} | 32'(vga_plot), 32'd0);
            if (grant != prev_grant && grant != '0) begin
                if (q_grant.size() == 0) chk("grant_unexpected", 32'(grant), 32'd0);
                else chk("grant_seq", 32'(grant), 32'(q_grant.pop_front()));
                chk("start_on_grant", 32'(eng_start), 32'(grant));
            end
            prev_grant = grant;
            if (ack != '0) begin
                if (q_ack.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
                else chk("ack_seq", 32'(ack), 32'(q_ack.pop_front()));
            end
            if (vga_plot) begin
                plot_cnt++;
                last_x = vga_x;
                last_y = vga_y;
                if (q_plot.size() == 0) chk("plot_unexpected", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
                else chk("plot_pixel", {14'd0, vga_x, vga_y, vga_colour}, q_plot.pop_front());
            end
        end
    end

    initial begin
        int base_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vga", {14'd0, vga_x, vga_y, vga_colour} | 32'(vga_plot), 32'd0);
        rst = 1'b0;

        // Single job on client 1, one-cycle req-to-start latency.
        push_job(1, 1, 5, 7, 5);
        req = 2'b10;
        @(posedge clk); #1;
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_start", 32'(eng_start), 32'h2);
        wait_ack(20, "single_ack_timeout");
        req = 2'b00;
        wait_idle(10, "single_idle_timeout");
        chk("single_grant_cleared", 32'(grant), 32'd0);

        // Round-robin with both requests held for four jobs.
        push_job(0, 2, 10, 20, 1);
        push_job(1, 2, 30, 40, 2);
        push_job(0, 2, 10, 20, 1);
        push_job(1, 2, 30, 40, 2);
        req = 2'b11;
        for (int j = 0; j < 4; j++) wait_ack(40, "rr_ack_timeout");
        req = 2'b00;
        wait_idle(10, "rr_idle_timeout");

        // Isolation: engine 1 shouts plot/done at the screen edge while 0 owns the port.
        manual[1] = 1'b1;
        eplot[1] = 1'b1; ex[1] = 8'd159; ey[1] = 7'd119; ec[1] = 3'd7; edone[1] = 1'b1;
        push_job(0, 3, 50, 60, 3);
        req = 2'b01;
        wait_ack(20, "iso_ack_timeout");
        req = 2'b00;
        wait_idle(10, "iso_idle_timeout");
        eplot[1] = 1'b0; ex[1] = '0; ey[1] = '0; ec[1] = '0; edone[1] = 1'b0;
        manual[1] = 1'b0;

        // Stale done: engine 0 already reports done, and keeps plotting x=9.
        manual[0] = 1'b1;
        edone[0] = 1'b1; eplot[0] = 1'b1; ex[0] = 8'd9; ey[0] = '0; ec[0] = '0;
        q_grant.push_back(2'b01);
        q_plot.push_back(pk(9, 0, 0));
        q_ack.push_back(2'b01);
        @(posedge clk); #1;
        req = 2'b01;
        @(posedge clk); #1;
        chk("stale_start", 32'(eng_start), 32'h1);
        @(posedge clk); #1;
        chk("stale_ack", 32'(ack), 32'h1);
        chk("stale_release_grant", 32'(grant), 32'h1);
        chk("stale_release_start", 32'(eng_start), 32'd0);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("stale_hold_grant", 32'(grant), 32'h1);
        chk("stale_hold_busy", 32'(busy), 32'd1);
        chk("stale_hold_plot", 32'(vga_plot), 32'd0);
        edone[0] = 1'b0; eplot[0] = 1'b0; ex[0] = '0;
        @(posedge clk); #1;
        chk("stale_grant_cleared", 32'(grant), 32'd0);
        chk("stale_busy_low", 32'(busy), 32'd0);
        manual[0] = 1'b0;

        // Full 160x120 fill on client 0.
        fill[0] = 1'b1; job_n[0] = 19200; bc[0] = 4;
        q_grant.push_back(2'b01);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                q_plot.push_back(pk(x, y, 4));
        q_ack.push_back(2'b01);
        base_cnt = plot_cnt;
        req = 2'b01;
        wait_ack(19300, "fill_ack_timeout");
        req = 2'b00;
        wait_idle(4, "fill_idle_timeout");
        chk("fill_plot_count", 32'(plot_cnt - base_cnt), 32'd19200);
        chk("fill_last_x", 32'(last_x), 32'd159);
        chk("fill_last_y", 32'(last_y), 32'd119);
        fill[0] = 1'b0;

        // Asynchronous reset in the middle of a client-1 job.
        manual[1] = 1'b1;
        q_grant.push_back(2'b10);
        req = 2'b10;
        @(posedge clk); #1;
        chk("rstmid_grant", 32'(grant), 32'h2);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rstmid_grant_zero", 32'(grant), 32'd0);
        chk("rstmid_start_zero", 32'(eng_start), 32'd0);
        chk("rstmid_ack_zero", 32'(ack), 32'd0);
        chk("rstmid_busy_zero", 32'(busy), 32'd0);
        chk("rstmid_plot_zero", 32'(vga_plot), 32'd0);
        @(posedge clk); #1;
        push_job(0, 1, 70, 80, 6);
        req = 2'b11;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_grant", 32'(grant), 32'h1);
        req = 2'b01;
        wait_ack(20, "post_rst_ack_timeout");
        req = 2'b00;
        wait_idle(10, "post_rst_idle_timeout");
        manual[1] = 1'b0;

        repeat (2) @(posedge clk);
        chk("grant_queue_empty", 32'(q_grant.size()), 32'd0);
        chk("ack_queue_empty", 32'(q_ack.size()), 32'd0);
        chk("plot_queue_empty", 32'(q_plot.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
